// File: rtl/uart_pkg.sv
// Shared types and encodings for the configurable UART.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  // Number of data bits carried by a frame for a given length code.
  function automatic logic [3:0] bit_count(input logic [1:0] len);
    return 4'd5 + {2'b00, len};
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte-push side of the UART transmitter: write strobe, data and FIFO status.
interface uart_tx_cfg_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;

  modport master (output wr_en, output wr_data,
                  input full, input empty, input level, input overflow);
  modport slave  (input wr_en, input wr_data,
                  output full, output empty, output level, output overflow);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers and an overflow pulse.
module uart_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [7:0]                      wr_data,
  input  logic                            rd_en,
  output logic [7:0]                      rd_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic push;
  logic pop;

  // A full FIFO rejects the push even when a pop happens in the same cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer and overflow-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      overflow <= wr_en && full;
    end
  end

  // Byte storage; contents are don't-care once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// FIFO-buffered UART transmitter with per-frame baud, length, parity and stop config.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_bits,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic                 tx,
  output logic                 busy,
  uart_tx_cfg_if.slave         bus
);
  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic                 stop_cnt, stop_n;
  logic                 tx_n;
  logic                 load;
  logic                 bit_end;
  logic [7:0]           head;
  logic [3:0]           n_bits;

  // Frame registers, captured when a byte is popped.
  logic [DIV_WIDTH-1:0] f_div;
  logic [2:0]           f_last;
  logic                 f_par_en;
  logic                 f_par_odd;
  logic                 f_stop2;
  logic [7:0]           f_data;
  logic                 par_acc, par_n;

  uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (load),
    .rd_data  (head),
    .full     (bus.full),
    .empty    (bus.empty),
    .level    (bus.level),
    .overflow (bus.overflow)
  );

  assign busy    = (state != IDLE);
  assign bit_end = (cnt == f_div - DIV_WIDTH'(1));
  assign n_bits  = bit_count(cfg_bits);

  // Control state: FSM, bit timer, bit index, stop counter and the registered line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_n;
      tx       <= tx_n;
    end
  end

  // Latch frame config and data on pop; divisor 0 is stored as 1.
  always_ff @(posedge clk) begin
    if (load) begin
      f_div     <= (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
      f_last    <= 3'(n_bits - 4'd1);
      f_par_en  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
      f_par_odd <= (cfg_parity == PAR_ODD);
      f_stop2   <= cfg_stop2;
      f_data    <= head;
    end
    par_acc <= par_n;
  end

  // Next-state, timer and line value for each frame phase.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    stop_n    = stop_cnt;
    tx_n      = tx;
    par_n     = par_acc;
    load      = 1'b0;

    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + DIV_WIDTH'(1);

    case (state)
      IDLE: begin
        tx_n  = 1'b1;
        cnt_n = '0;
        if (tx_en && !bus.empty) begin
          load    = 1'b1;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = f_data[0];
          par_n     = 1'b0;
        end
      end
      DATA: begin
        if (bit_end) begin
          par_n = par_acc ^ f_data[bit_idx];
          if (bit_idx == f_last) begin
            stop_n = 1'b0;
            if (f_par_en) begin
              state_n = PARITY;
              tx_n    = par_n ^ f_par_odd;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = f_data[bit_idx + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          stop_n  = 1'b0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (f_stop2 && !stop_cnt) begin
            stop_n = 1'b1;
          end else begin
            stop_n = 1'b0;
            if (tx_en && !bus.empty) begin
              load    = 1'b1;
              state_n = START;
              tx_n    = 1'b0;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
